// File: rtl/cgra_seq_pkg.sv
// Shared types for the CGRA configuration sequencer: command word layout,
// opcodes, abort codes and FSM state encoding.
package cgra_seq_pkg;

  localparam int CMD_ADDR_W = 64;
  localparam int CMD_DATA_W = 64;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_POLL  = 2'd1,
    OP_WAIT  = 2'd2,
    OP_END   = 2'd3
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_DATA_W-1:0] mask;
  } cmd_t;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_RESP         = 2'd1,
    ERR_POLL_TIMEOUT = 2'd2,
    ERR_PC_OVERFLOW  = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_WR_REQ  = 4'd3,
    ST_WR_RESP = 4'd4,
    ST_RD_REQ  = 4'd5,
    ST_RD_DATA = 4'd6,
    ST_WAIT    = 4'd7,
    ST_DONE    = 4'd8,
    ST_ERROR   = 4'd9
  } state_e;

endpackage

// File: rtl/cgra_cfg_sequencer.sv
// AXI4 master that replays a command table (WRITE / POLL / WAIT / END) to
// configure and start the CGRA. One transaction in flight at most; all
// beats are single full-width beats.
module cgra_cfg_sequencer
  import cgra_seq_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID         = 0,
  parameter int CMD_DEPTH      = 32,
  parameter int POLL_LIMIT     = 1024,
  localparam int PCW           = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [1:0]                  err_code_o,
  output logic [PCW-1:0]              pc_o,
  output logic [PCW-1:0]              cmd_addr_o,
  input  cmd_t                        cmd_i,
  // write address channel
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [7:0]                  aw_len_o,
  output logic [2:0]                  aw_size_o,
  output logic [1:0]                  aw_burst_o,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  // write data channel
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  // write response channel
  input  logic [1:0]                  b_resp_i,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  // read address channel
  output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [7:0]                  ar_len_o,
  output logic [2:0]                  ar_size_o,
  output logic [1:0]                  ar_burst_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  // read data channel
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_valid_i,
  output logic                        r_ready_o
);

  localparam int PCNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0]    PC_LAST   = PCW'(CMD_DEPTH - 1);
  localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_LIMIT - 1);

  state_e                    state_r, state_s;
  logic [PCW-1:0]            pc_r, pc_s;
  logic [AXI_ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [AXI_DATA_WIDTH-1:0] data_r, data_s;
  logic [AXI_DATA_WIDTH-1:0] mask_r, mask_s;
  logic [PCNT_W-1:0]         poll_cnt_r, poll_cnt_s;
  logic [31:0]               wait_cnt_r, wait_cnt_s;
  logic                      aw_valid_r, aw_valid_s;
  logic                      w_valid_r, w_valid_s;
  logic                      done_r, done_s;
  logic                      error_r, error_s;
  err_e                      err_code_r, err_code_s;
  logic                      adv_s;

  // A channel counts as finished once its valid has dropped or it handshakes now.
  logic aw_fin_s, w_fin_s, b_err_s, r_err_s, r_match_s;
  assign aw_fin_s  = ~aw_valid_r | aw_ready_i;
  assign w_fin_s   = ~w_valid_r  | w_ready_i;
  assign b_err_s   = (b_resp_i == 2'b10) || (b_resp_i == 2'b11);
  assign r_err_s   = (r_resp_i == 2'b10) || (r_resp_i == 2'b11);
  assign r_match_s = ((r_data_i & mask_r) == (data_r & mask_r));

  // Next-state, datapath and sticky flag computation.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    addr_s     = addr_r;
    data_s     = data_r;
    mask_s     = mask_r;
    poll_cnt_s = poll_cnt_r;
    wait_cnt_s = wait_cnt_r;
    aw_valid_s = aw_valid_r;
    w_valid_s  = w_valid_r;
    done_s     = done_r;
    error_s    = error_r;
    err_code_s = err_code_r;
    adv_s      = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_s    = ST_FETCH;
          pc_s       = '0;
          poll_cnt_s = '0;
          done_s     = 1'b0;
          error_s    = 1'b0;
          err_code_s = ERR_NONE;
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        state_s = ST_DECODE;
      end
      ST_DECODE: begin
        addr_s = cmd_i.addr[AXI_ADDR_WIDTH-1:0];
        data_s = cmd_i.data[AXI_DATA_WIDTH-1:0];
        mask_s = cmd_i.mask[AXI_DATA_WIDTH-1:0];
        case (cmd_i.op)
          OP_WRITE: begin
            state_s    = ST_WR_REQ;
            aw_valid_s = 1'b1;
            w_valid_s  = 1'b1;
          end
          OP_POLL: begin
            state_s = ST_RD_REQ;
          end
          OP_WAIT: begin
            state_s    = ST_WAIT;
            wait_cnt_s = cmd_i.data[31:0];
          end
          OP_END: begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end
          default: begin
            state_s = ST_IDLE;
          end
        endcase
      end
      ST_WR_REQ: begin
        if (aw_ready_i) begin
          aw_valid_s = 1'b0;
        end else begin
          aw_valid_s = aw_valid_r;
        end
        if (w_ready_i) begin
          w_valid_s = 1'b0;
        end else begin
          w_valid_s = w_valid_r;
        end
        if (aw_fin_s && w_fin_s) begin
          state_s = ST_WR_RESP;
        end else begin
          state_s = ST_WR_REQ;
        end
      end
      ST_WR_RESP: begin
        if (b_valid_i) begin
          if (b_err_s) begin
            state_s    = ST_ERROR;
            error_s    = 1'b1;
            err_code_s = ERR_RESP;
          end else begin
            adv_s = 1'b1;
          end
        end else begin
          state_s = ST_WR_RESP;
        end
      end
      ST_RD_REQ: begin
        if (ar_ready_i) begin
          state_s = ST_RD_DATA;
        end else begin
          state_s = ST_RD_REQ;
        end
      end
      ST_RD_DATA: begin
        if (r_valid_i) begin
          if (r_err_s) begin
            state_s    = ST_ERROR;
            error_s    = 1'b1;
            err_code_s = ERR_RESP;
          end else if (r_match_s) begin
            adv_s = 1'b1;
          end else if (poll_cnt_r == POLL_LAST) begin
            state_s    = ST_ERROR;
            error_s    = 1'b1;
            err_code_s = ERR_POLL_TIMEOUT;
          end else begin
            poll_cnt_s = poll_cnt_r + PCNT_W'(1);
            state_s    = ST_RD_REQ;
          end
        end else begin
          state_s = ST_RD_DATA;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 32'd0) begin
          adv_s = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r - 32'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Advancing past the last table entry without END is an overflow, not a wrap.
    if (adv_s) begin
      poll_cnt_s = '0;
      if (pc_r == PC_LAST) begin
        state_s    = ST_ERROR;
        error_s    = 1'b1;
        err_code_s = ERR_PC_OVERFLOW;
      end else begin
        pc_s    = pc_r + PCW'(1);
        state_s = ST_FETCH;
      end
    end else begin
      pc_s = pc_s;
    end
  end

  // State and datapath registers; reset drops every valid at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      pc_r       <= '0;
      addr_r     <= '0;
      data_r     <= '0;
      mask_r     <= '0;
      poll_cnt_r <= '0;
      wait_cnt_r <= 32'd0;
      aw_valid_r <= 1'b0;
      w_valid_r  <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      mask_r     <= mask_s;
      poll_cnt_r <= poll_cnt_s;
      wait_cnt_r <= wait_cnt_s;
      aw_valid_r <= aw_valid_s;
      w_valid_r  <= w_valid_s;
      done_r     <= done_s;
      error_r    <= error_s;
      err_code_r <= err_code_s;
    end
  end

  assign busy_o     = !((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));
  assign done_o     = done_r;
  assign error_o    = error_r;
  assign err_code_o = err_code_r;
  assign pc_o       = pc_r;
  assign cmd_addr_o = pc_r;

  assign aw_id_o    = AXI_ID_WIDTH'(AXI_ID);
  assign aw_addr_o  = addr_r;
  assign aw_len_o   = 8'd0;
  assign aw_size_o  = 3'b011;
  assign aw_burst_o = 2'b01;
  assign aw_valid_o = aw_valid_r;

  assign w_data_o   = data_r;
  assign w_strb_o   = '1;
  assign w_last_o   = 1'b1;
  assign w_valid_o  = w_valid_r;

  assign b_ready_o  = (state_r == ST_WR_RESP);

  assign ar_id_o    = AXI_ID_WIDTH'(AXI_ID);
  assign ar_addr_o  = addr_r;
  assign ar_len_o   = 8'd0;
  assign ar_size_o  = 3'b011;
  assign ar_burst_o = 2'b01;
  assign ar_valid_o = (state_r == ST_RD_REQ);

  assign r_ready_o  = (state_r == ST_RD_DATA);

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// Directed bench for cgra_cfg_sequencer: command ROM, reactive AXI slave
// model and write/read scoreboards.
module tb_cgra_cfg_sequencer;
  import cgra_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int PLIM  = 8;
  localparam logic [63:0] BAD_ADDR = 64'h0000_0000_DEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy_o, done_o, error_o;
  logic [1:0]  err_code_o, pc_o, cmd_addr_o;
  cmd_t        cmd_q;
  logic [3:0]  aw_id_o, ar_id_o;
  logic [63:0] aw_addr_o, ar_addr_o, w_data_o;
  logic [7:0]  aw_len_o, ar_len_o, w_strb_o;
  logic [2:0]  aw_size_o, ar_size_o;
  logic [1:0]  aw_burst_o, ar_burst_o;
  logic        aw_valid_o, w_valid_o, w_last_o, ar_valid_o, b_ready_o, r_ready_o;
  logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [63:0] r_data;

  cmd_t table_r [DEPTH];

  typedef struct packed { logic [63:0] addr; logic [63:0] data; } wr_t;
  wr_t         exp_wr_q[$];
  logic [63:0] exp_rd_q[$];
  logic [63:0] poll_q[$];

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int aw_delay = 0, w_delay = 0;

  always #5 clk = ~clk;

  // Command ROM with one cycle of read latency.
  always @(posedge clk) cmd_q <= table_r[cmd_addr_o];

  cgra_cfg_sequencer #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_ID(0),
    .CMD_DEPTH(DEPTH), .POLL_LIMIT(PLIM)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
    .pc_o(pc_o), .cmd_addr_o(cmd_addr_o), .cmd_i(cmd_q),
    .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
    .aw_burst_o(aw_burst_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready),
    .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready_o),
    .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .ar_burst_o(ar_burst_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready),
    .r_data_i(r_data), .r_resp_i(r_resp), .r_valid_i(r_valid), .r_ready_o(r_ready_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int idx, input op_e op, input logic [63:0] addr,
                         input logic [63:0] data, input logic [63:0] mask);
    table_r[idx] = '{op: op, addr: addr, data: data, mask: mask};
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int n;
    n = 0;
    while (!(done_o || error_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, {63'd0, (done_o | error_o)}, 64'd1);
  endtask

  // Measure cycles from the start edge until pc_o reaches 1.
  task automatic measure_pc0(input string tag, input int exp_cycles);
    int n;
    n = 0;
    @(negedge clk); start = 1'b1;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (pc_o != 2'd1 && n < 100);
    check(tag, n, exp_cycles);
  endtask

  // Reactive AXI slave: decides ready/valid on the falling edge, so a
  // handshake seen here takes place at the following rising edge.
  initial begin : slave
    logic        aw_got, w_got, b_pend, r_pend, b_hs, r_hs;
    int          aw_wait, w_wait;
    logic [63:0] got_addr, got_data, e_addr;
    wr_t         e;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = 64'd0; r_resp = 2'b00;
    aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
    aw_wait = 0; w_wait = 0; got_addr = 64'd0; got_data = 64'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; ar_ready = 1'b0; r_valid = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
        aw_wait = 0; w_wait = 0;
      end else begin
        if (b_hs) b_valid = 1'b0;
        if (r_hs) r_valid = 1'b0;
        if (b_pend) begin
          b_valid = 1'b1;
          b_resp  = (got_addr == BAD_ADDR) ? 2'b11 : 2'b00;
          b_pend  = 1'b0;
        end
        if (r_pend) begin
          r_valid = 1'b1;
          r_data  = (poll_q.size() != 0) ? poll_q.pop_front() : 64'd0;
          r_resp  = 2'b00;
          r_pend  = 1'b0;
        end
        if (aw_valid_o) begin
          if (aw_wait < aw_delay) begin
            aw_ready = 1'b0; aw_wait++;
          end else begin
            aw_ready = 1'b1; aw_wait = 0; got_addr = aw_addr_o; aw_got = 1'b1; aw_cnt++;
          end
        end else begin
          aw_ready = 1'b0;
        end
        if (w_valid_o) begin
          if (w_wait < w_delay) begin
            w_ready = 1'b0; w_wait++;
          end else begin
            w_ready = 1'b1; w_wait = 0; got_data = w_data_o; w_got = 1'b1; w_cnt++;
          end
        end else begin
          w_ready = 1'b0;
        end
        if (aw_got && w_got) begin
          aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
          check("write_expected", {63'd0, (exp_wr_q.size() != 0)}, 64'd1);
          if (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            check("wr_addr", got_addr, e.addr);
            check("wr_data", got_data, e.data);
          end
        end
        if (ar_valid_o) begin
          ar_ready = 1'b1; ar_cnt++; r_pend = 1'b1;
          check("read_expected", {63'd0, (exp_rd_q.size() != 0)}, 64'd1);
          if (exp_rd_q.size() != 0) begin
            e_addr = exp_rd_q.pop_front();
            check("rd_addr", ar_addr_o, e_addr);
          end
        end else begin
          ar_ready = 1'b0;
        end
        b_hs = b_valid & b_ready_o;
        r_hs = r_valid & r_ready_o;
      end
    end
  end

  initial begin : stim
    int c0, c1, c2;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) set_cmd(i, OP_END, 64'd0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state and constant AXI fields
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    check("rst_err_code", err_code_o, 2'd0);
    check("rst_pc", pc_o, 2'd0);
    check("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o}, 3'b000);
    check("rst_readies", {b_ready_o, r_ready_o}, 2'b00);
    check("fixed_aw", {aw_id_o, aw_len_o, aw_size_o, aw_burst_o}, {4'd0, 8'd0, 3'b011, 2'b01});
    check("fixed_ar", {ar_id_o, ar_len_o, ar_size_o, ar_burst_o}, {4'd0, 8'd0, 3'b011, 2'b01});
    check("fixed_w", {w_strb_o, w_last_o}, {8'hFF, 1'b1});

    // Single write with aw_ready held off for 3 cycles
    set_cmd(0, OP_WRITE, 64'h5000_0050, 64'h1, 64'd0);
    set_cmd(1, OP_END, 64'd0, 64'd0, 64'd0);
    exp_wr_q.push_back('{addr: 64'h5000_0050, data: 64'h1});
    aw_delay = 3; w_delay = 0;
    c0 = aw_cnt; c1 = w_cnt;
    pulse_start();
    check("t1_busy", busy_o, 1'b1);
    wait_finish("t1");
    check("t1_done", done_o, 1'b1);
    check("t1_busy_end", busy_o, 1'b0);
    check("t1_pc", pc_o, 2'd1);
    check("t1_aw_count", aw_cnt - c0, 1);
    check("t1_w_count", w_cnt - c1, 1);
    check("t1_sb_empty", exp_wr_q.size(), 0);

    // Two writes, W accepted before AW
    set_cmd(0, OP_WRITE, 64'h5000_0010, 64'hA5A5_0000_1234_5678, 64'd0);
    set_cmd(1, OP_WRITE, 64'h5000_0018, 64'h0000_0000_CAFE_F00D, 64'd0);
    set_cmd(2, OP_END, 64'd0, 64'd0, 64'd0);
    exp_wr_q.push_back('{addr: 64'h5000_0010, data: 64'hA5A5_0000_1234_5678});
    exp_wr_q.push_back('{addr: 64'h5000_0018, data: 64'h0000_0000_CAFE_F00D});
    aw_delay = 2; w_delay = 0;
    c0 = aw_cnt; c1 = w_cnt;
    pulse_start();
    wait_finish("t2");
    check("t2_done", {done_o, error_o}, 2'b10);
    check("t2_pc", pc_o, 2'd2);
    check("t2_aw_count", aw_cnt - c0, 2);
    check("t2_w_count", w_cnt - c1, 2);
    check("t2_sb_empty", exp_wr_q.size(), 0);

    // POLL that matches on the third read
    aw_delay = 0; w_delay = 0;
    set_cmd(0, OP_POLL, 64'h5000_0070, 64'h1, 64'h1);
    set_cmd(1, OP_END, 64'd0, 64'd0, 64'd0);
    poll_q.push_back(64'h0); poll_q.push_back(64'hFFFF_FFFE); poll_q.push_back(64'h3);
    for (int i = 0; i < 3; i++) exp_rd_q.push_back(64'h5000_0070);
    c2 = ar_cnt;
    pulse_start();
    wait_finish("t3");
    check("t3_done", {done_o, error_o}, 2'b10);
    check("t3_ar_count", ar_cnt - c2, 3);
    check("t3_pc", pc_o, 2'd1);

    // POLL that never matches times out after POLL_LIMIT reads
    set_cmd(0, OP_WAIT, 64'd0, 64'd0, 64'd0);
    set_cmd(1, OP_POLL, 64'h5000_0080, 64'h1, 64'h1);
    set_cmd(2, OP_END, 64'd0, 64'd0, 64'd0);
    for (int i = 0; i < PLIM; i++) exp_rd_q.push_back(64'h5000_0080);
    c2 = ar_cnt;
    pulse_start();
    wait_finish("t4");
    check("t4_flags", {done_o, error_o, busy_o}, 3'b010);
    check("t4_err_code", err_code_o, 2'd2);
    check("t4_pc", pc_o, 2'd1);
    check("t4_ar_count", ar_cnt - c2, PLIM);
    check("t4_rd_sb_empty", exp_rd_q.size(), 0);

    // DECERR on write, then restart clears the error
    set_cmd(0, OP_WRITE, BAD_ADDR, 64'h77, 64'd0);
    set_cmd(1, OP_END, 64'd0, 64'd0, 64'd0);
    exp_wr_q.push_back('{addr: BAD_ADDR, data: 64'h77});
    pulse_start();
    wait_finish("t5");
    check("t5_error", {done_o, error_o}, 2'b01);
    check("t5_err_code", err_code_o, 2'd1);
    check("t5_pc", pc_o, 2'd0);
    set_cmd(0, OP_WRITE, 64'h5000_0050, 64'h2, 64'd0);
    exp_wr_q.push_back('{addr: 64'h5000_0050, data: 64'h2});
    pulse_start();
    check("t5_error_cleared", {error_o, err_code_o, busy_o}, {1'b0, 2'd0, 1'b1});
    wait_finish("t5b");
    check("t5_rerun_done", {done_o, error_o}, 2'b10);
    check("t5_sb_empty", exp_wr_q.size(), 0);

    // Table without END overflows the PC
    for (int i = 0; i < DEPTH; i++) set_cmd(i, OP_WAIT, 64'd0, 64'd0, 64'd0);
    pulse_start();
    wait_finish("t6");
    check("t6_error", {done_o, error_o}, 2'b01);
    check("t6_err_code", err_code_o, 2'd3);
    check("t6_pc", pc_o, 2'd3);

    // WAIT timing: 2 overhead cycles, n+1 cycles counting, plus the start edge
    set_cmd(0, OP_WAIT, 64'd0, 64'd5, 64'd0);
    set_cmd(1, OP_END, 64'd0, 64'd0, 64'd0);
    measure_pc0("t7_wait5_cycles", 9);
    wait_finish("t7");
    check("t7_done", done_o, 1'b1);
    set_cmd(0, OP_WAIT, 64'd0, 64'd0, 64'd0);
    measure_pc0("t7_wait0_cycles", 4);
    wait_finish("t7b");

    // Reset asserted in the middle of WR_REQ
    set_cmd(0, OP_WRITE, 64'h5000_0090, 64'h9, 64'd0);
    aw_delay = 20; w_delay = 20;
    exp_wr_q.push_back('{addr: 64'h5000_0090, data: 64'h9});
    pulse_start();
    repeat (3) @(negedge clk);
    check("t8_aw_valid_before", {aw_valid_o, w_valid_o}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("t8_valids_in_reset", {aw_valid_o, w_valid_o, ar_valid_o}, 3'b000);
    check("t8_busy_in_reset", busy_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_wr_q.delete();
    aw_delay = 0; w_delay = 0;
    @(negedge clk);
    check("t8_after_reset", {busy_o, done_o, error_o, pc_o}, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
